// File: rtl/down_timer.sv
// down_timer: loadable down-counter with IDLE/RUN/DONE handshake.
// It loads a count on start, decrements once per ei tick and pulses eu
// once when it expires. It then holds done until the consumer acks.
module down_timer #(
    parameter int unsigned N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] load_val,
    input  logic         ei,
    input  logic         abort,
    input  logic         ack,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         eu
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   q_q, q_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           eu_q, eu_d;

    // Next-state, next-count and registered flag decode
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        eu_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        q_d     = load_val;
                        state_d = S_RUN;
                    end else begin
                        q_d     = '0;
                        state_d = S_DONE;
                        eu_d    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // abort wins over a tick in the same cycle; the count is frozen
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ei) begin
                    if (q_q == N'(1)) begin
                        q_d     = '0;
                        state_d = S_DONE;
                        eu_d    = 1'b1;
                    end else begin
                        q_d = q_q - N'(1);
                    end
                end
            end
            S_DONE: begin
                q_d = '0;
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                q_d     = '0;
            end
        endcase

        // busy/done are decoded from the next state, so they are flop outputs
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eu_q    <= eu_d;
        end
    end

    assign q    = q_q;
    assign busy = busy_q;
    assign done = done_q;
    assign eu   = eu_q;

endmodule
